minimig_bank_access: RTL and testbench
======================================

MINIMIG_BANK_ACCESS -- requirements
Module: minimig_bank_access

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, range 1..15: number of memory strobe cycles per access.
REQ-002 SHALL have port clk, input, 1: single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port bank, input, 8: 512 KB block select vector from the bank mapper; not guaranteed one-hot.
REQ-005 SHALL have port addr, input, 18: word address within the 512 KB block (A18..A1).
REQ-006 SHALL have port req, input, 1: single-cycle access request strobe.
REQ-007 SHALL have port we, input, 1: 1 = write, 0 = read; sampled with req.
REQ-008 SHALL have port be, input, 2: byte enables {UDS, LDS}; sampled with req.
REQ-009 SHALL have port wdata, input, 16: write data; sampled with req.
REQ-010 SHALL have port kick_wp, input, 1: 1 = bank 7 (Kickstart) is write-protected.
REQ-011 SHALL have port mem_din, input, 16: read data from RAM.
REQ-012 SHALL have outputs mem_addr (21, {bank index[2:0], addr}), mem_cs, mem_oe and mem_we (1 each), mem_be (2), mem_dout (16).
REQ-013 SHALL have outputs rdata (16), ack (1, one-cycle completion pulse), err (1, valid with ack) and busy (1).

Function
REQ-014 States SHALL be IDLE, SETUP, STROBE and DONE.
REQ-015 In IDLE with req=1, SHALL latch bank, addr, we, be and wdata.
REQ-016 In IDLE with req=1, SHALL priority-encode bank to a 3-bit index, lowest set bit wins (bank=0x21 gives index 0).
REQ-017 In IDLE with req=1 and bank=0, SHALL go directly to DONE with err=1 and no memory strobes.
REQ-018 In IDLE with req=1, we=1, index 7 and kick_wp=1, SHALL go directly to DONE with err=0 and no memory strobes.
REQ-019 In IDLE with req=1 in all other cases, SHALL go to SETUP.
REQ-020 In SETUP (1 cycle), mem_cs SHALL be 1, mem_addr, mem_be and mem_dout SHALL be driven from the latches, and mem_oe SHALL equal !we; mem_we SHALL be 0.
REQ-021 STROBE SHALL last exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter.
REQ-022 In STROBE, mem_cs SHALL be 1, mem_we SHALL equal we and mem_oe SHALL equal !we.
REQ-023 On the last STROBE cycle of a read, SHALL capture mem_din into rdata.
REQ-024 In DONE (1 cycle), ack SHALL be 1 and all mem strobes SHALL be 0; next state SHALL be IDLE.
REQ-025 Request-to-ack latency SHALL be 2+WAIT_CYCLES cycles for a normal access and 1 cycle for an error or protected access.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 req while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-028 mem_addr, mem_be and mem_dout SHALL remain stable from SETUP through the last STROBE cycle.
REQ-029 rdata SHALL hold its value until the next completed read; writes and error or protected accesses SHALL leave rdata unchanged.
REQ-030 req in the DONE cycle SHALL be ignored; back-to-back requests SHALL be accepted no earlier than the cycle after ack.

Reset
REQ-031 While reset=1, SHALL force state to IDLE and the wait counter to 0.
REQ-032 While reset=1, SHALL force mem_cs, mem_oe, mem_we, ack, err and busy to 0.
REQ-033 While reset=1, SHALL force mem_addr, mem_be, mem_dout and rdata to 0.
REQ-034 Reset asserted mid-access SHALL deassert the memory strobes immediately, without waiting for a clock edge.
REQ-035 An access interrupted by reset SHALL produce no ack.

Structure
REQ-036 The state encoding, the bank index width (3) and the Kickstart bank index constant (7) SHALL reside in a shared minimig_mem_pkg.
REQ-037 The priority encoder SHALL be a sub-module, minimig_bank_encode (8-bit vector in; 3-bit index and valid flag out).
REQ-038 The rest of the block SHALL be a single FSM with registered outputs.

Verification
REQ-039 Read, WAIT_CYCLES=2: bank=0x04, addr=0x12345, mem_din=0xBEEF -> mem_addr=0x092345, mem_oe high 3 cycles, ack at cycle 4, rdata=0xBEEF, err=0.
REQ-040 Write: bank=0x10, be=2'b10, wdata=0xA55A -> mem_we high exactly 2 cycles, mem_be=2'b10, mem_dout=0xA55A, ack at cycle 4, rdata unchanged.
REQ-041 Protected write: bank=0x80, we=1, kick_wp=1 -> no mem_cs, ack at cycle 1, err=0; the same request with kick_wp=0 -> normal write, mem_addr[20:18]=7.
REQ-042 Empty bank: bank=0x00 read -> ack at cycle 1, err=1, no strobes; bank=0x21 -> index 0 selected.
REQ-043 Busy handling: second req two cycles after the first -> ignored, exactly one ack; req on the cycle after ack -> accepted.
REQ-044 Reset mid-STROBE: reset pulsed during cycle 2 of a write -> mem_we and mem_cs low immediately, no ack, next req completes normally.

Source files
------------

// File: rtl/minimig_mem_pkg.sv
// rtl/minimig_mem_pkg.sv - shared constants and state encoding for the Minimig memory bank access path
package minimig_mem_pkg;

    localparam int BANK_IDX_W = 3;
    localparam logic [BANK_IDX_W-1:0] KICK_BANK_IDX = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_DONE   = 2'd3
    } bank_state_t;

endpackage

// File: rtl/minimig_bank_encode.sv
// rtl/minimig_bank_encode.sv - priority encoder for the bank select vector, lowest set bit wins
module minimig_bank_encode
    import minimig_mem_pkg::*;
(
    input  logic [7:0]            bank,
    output logic [BANK_IDX_W-1:0] index,
    output logic                  valid
);

    always_comb begin
        index = '0;
        valid = 1'b0;
        // Scan high to low so the lowest set bit is the last to write.
        for (int i = 7; i >= 0; i--) begin
            if (bank[i]) begin
                index = BANK_IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/minimig_bank_access.sv
// rtl/minimig_bank_access.sv - single-access RAM sequencer with bank decode and Kickstart write protect
module minimig_bank_access
    import minimig_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  bank,
    input  logic [17:0] addr,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  be,
    input  logic [15:0] wdata,
    input  logic        kick_wp,
    input  logic [15:0] mem_din,
    output logic [20:0] mem_addr,
    output logic        mem_cs,
    output logic        mem_oe,
    output logic        mem_we,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_dout,
    output logic [15:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    bank_state_t           state, state_n;
    logic [3:0]            wait_cnt, wait_cnt_n;
    logic                  we_q, we_n;
    logic [BANK_IDX_W-1:0] enc_index;
    logic                  enc_valid;
    logic                  load, capture, err_n;
    logic                  cs_n, oe_n, mwe_n;

    minimig_bank_encode u_encode (
        .bank  (bank),
        .index (enc_index),
        .valid (enc_valid)
    );

    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        load       = 1'b0;
        capture    = 1'b0;
        err_n      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    load = 1'b1;
                    if (!enc_valid) begin
                        state_n = ST_DONE;
                        err_n   = 1'b1;
                    end else if (we && kick_wp && enc_index == KICK_BANK_IDX) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                state_n    = ST_STROBE;
                wait_cnt_n = WAIT_LAST;
            end
            ST_STROBE: begin
                if (wait_cnt == 4'd0) begin
                    state_n = ST_DONE;
                    capture = !we_q;
                end else begin
                    wait_cnt_n = wait_cnt - 4'd1;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase

        // Outputs are computed for the upcoming state so they come straight from flops.
        we_n  = load ? we : we_q;
        cs_n  = (state_n == ST_SETUP) || (state_n == ST_STROBE);
        oe_n  = cs_n && !we_n;
        mwe_n = (state_n == ST_STROBE) && we_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            we_q     <= 1'b0;
            mem_addr <= '0;
            mem_be   <= '0;
            mem_dout <= '0;
            rdata    <= '0;
            mem_cs   <= 1'b0;
            mem_oe   <= 1'b0;
            mem_we   <= 1'b0;
            ack      <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
            we_q     <= we_n;
            if (load) begin
                mem_addr <= {enc_index, addr};
                mem_be   <= be;
                mem_dout <= wdata;
            end
            if (capture) begin
                rdata <= mem_din;
            end
            mem_cs <= cs_n;
            mem_oe <= oe_n;
            mem_we <= mwe_n;
            ack    <= (state_n == ST_DONE);
            err    <= err_n;
            busy   <= (state_n != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_minimig_bank_access.sv
// tb/tb_minimig_bank_access.sv - self-checking bench for minimig_bank_access
module tb_minimig_bank_access;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  bank;
    logic [17:0] addr;
    logic        req;
    logic        we;
    logic [1:0]  be;
    logic [15:0] wdata;
    logic        kick_wp;
    logic [15:0] mem_din;
    logic [20:0] mem_addr;
    logic        mem_cs, mem_oe, mem_we;
    logic [1:0]  mem_be;
    logic [15:0] mem_dout;
    logic [15:0] rdata;
    logic        ack, err, busy;

    int tests = 0;
    int fails = 0;
    logic [15:0] exp_rdata = 16'h0000;

    typedef struct {
        logic [7:0]  bank;
        logic [17:0] addr;
        logic        we;
        logic [1:0]  be;
        logic [15:0] wdata;
        logic        kick_wp;
        logic [15:0] din;
        int          exp_lat;
        logic        exp_err;
        int          exp_cs;
        logic [20:0] exp_addr;
    } vec_t;

    minimig_bank_access #(.WAIT_CYCLES(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .bank     (bank),
        .addr     (addr),
        .req      (req),
        .we       (we),
        .be       (be),
        .wdata    (wdata),
        .kick_wp  (kick_wp),
        .mem_din  (mem_din),
        .mem_addr (mem_addr),
        .mem_cs   (mem_cs),
        .mem_oe   (mem_oe),
        .mem_we   (mem_we),
        .mem_be   (mem_be),
        .mem_dout (mem_dout),
        .rdata    (rdata),
        .ack      (ack),
        .err      (err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [7:0] b, input logic [17:0] a, input logic w,
                                   input logic [1:0] e, input logic [15:0] d, input logic k,
                                   input logic [15:0] din);
        vec_t v;
        int   idx = -1;
        for (int i = 7; i >= 0; i--) if (b[i]) idx = i;
        v.bank = b; v.addr = a; v.we = w; v.be = e; v.wdata = d; v.kick_wp = k; v.din = din;
        v.exp_err = 1'b0; v.exp_addr = '0;
        if (idx < 0) begin
            v.exp_lat = 1; v.exp_err = 1'b1; v.exp_cs = 0;
        end else if (w && k && idx == 7) begin
            v.exp_lat = 1; v.exp_cs = 0;
        end else begin
            v.exp_lat  = 2 + W;
            v.exp_cs   = 1 + W;
            v.exp_addr = 21'(idx * 262144 + int'(a));
        end
        return v;
    endfunction

    // Caller is at a negedge; returns at the negedge where ack is observed.
    task automatic run_access(input vec_t v, input int inj_at);
        int   n = 1;
        int   cs_n = 0, oe_n = 0, we_n = 0, bad_bus = 0, bad_busy = 0;
        logic got_ack = 1'b0;
        logic err_seen = 1'b0;
        bank = v.bank; addr = v.addr; we = v.we; be = v.be; wdata = v.wdata;
        kick_wp = v.kick_wp; mem_din = v.din; req = 1'b1;
        @(negedge clk);
        while (!got_ack && n < 40) begin
            req = (n == inj_at);
            if (mem_cs) begin
                cs_n++;
                if (mem_addr != v.exp_addr || mem_be != v.be || mem_dout != v.wdata) bad_bus++;
            end
            if (mem_oe) oe_n++;
            if (mem_we) we_n++;
            if (!busy) bad_busy++;
            if (ack) begin
                got_ack  = 1'b1;
                err_seen = err;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        req = 1'b0;
        if (!v.we && v.exp_cs > 0) exp_rdata = v.din;
        check("latency", got_ack ? n : -1, v.exp_lat);
        check("err", int'(err_seen), int'(v.exp_err));
        check("cs_cycles", cs_n, v.exp_cs);
        check("oe_cycles", oe_n, v.we ? 0 : v.exp_cs);
        check("we_cycles", we_n, (v.we && v.exp_cs > 0) ? v.exp_cs - 1 : 0);
        check("bus_stable", bad_bus, 0);
        check("busy", bad_busy, 0);
        check("rdata", int'(rdata), int'(exp_rdata));
    endtask

    task automatic count_acks(input int cycles, output int acks);
        acks = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (ack) acks++;
        end
    endtask

    vec_t tbl[7];
    vec_t rv;
    int   acks;

    initial begin
        tbl[0] = '{8'h04, 18'h12345, 1'b0, 2'b11, 16'h0000, 1'b0, 16'hBEEF, 4, 1'b0, 3, 21'h092345};
        tbl[1] = '{8'h10, 18'h00100, 1'b1, 2'b10, 16'hA55A, 1'b0, 16'h1111, 4, 1'b0, 3, 21'h100100};
        tbl[2] = '{8'h80, 18'h3FFFF, 1'b1, 2'b11, 16'h1234, 1'b1, 16'h2222, 1, 1'b0, 0, 21'h000000};
        tbl[3] = '{8'h80, 18'h3FFFF, 1'b1, 2'b11, 16'h1234, 1'b0, 16'h2222, 4, 1'b0, 3, 21'h1FFFFF};
        tbl[4] = '{8'h00, 18'h00040, 1'b0, 2'b11, 16'h0000, 1'b0, 16'h3333, 1, 1'b1, 0, 21'h000000};
        tbl[5] = '{8'h21, 18'h00001, 1'b0, 2'b01, 16'h0000, 1'b0, 16'h5A5A, 4, 1'b0, 3, 21'h000001};
        tbl[6] = '{8'h80, 18'h00000, 1'b0, 2'b11, 16'h0000, 1'b1, 16'hCAFE, 4, 1'b0, 3, 21'h1C0000};

        reset = 1'b1; req = 1'b0; bank = '0; addr = '0; we = 1'b0; be = '0;
        wdata = '0; kick_wp = 1'b0; mem_din = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_strobes", {mem_cs, mem_oe, mem_we, ack, err, busy}, 0);
        check("rst_bus", int'(mem_addr) | int'(mem_be) | int'(mem_dout) | int'(rdata), 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_access(tbl[i], 0);
            @(negedge clk);
        end

        // Second request two cycles in is dropped; exactly one ack results.
        run_access(tbl[0], 2);
        count_acks(6, acks);
        check("busy_ignored_acks", acks, 0);
        check("busy_after_drop", int'(busy), 0);

        // Request during the ack cycle is dropped.
        run_access(tbl[5], 0);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        count_acks(6, acks);
        check("done_req_ignored", acks, 0);

        // Request on the cycle after ack is accepted.
        run_access(tbl[1], 0);
        @(negedge clk);
        run_access(tbl[0], 0);
        @(negedge clk);

        // Reset pulsed in the second cycle of a write.
        bank = 8'h02; addr = 18'h0ABCD; we = 1'b1; be = 2'b11; wdata = 16'h7777;
        kick_wp = 1'b0; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check("pre_rst_we", int'(mem_we), 1);
        reset = 1'b1;
        #1;
        check("rst_async_strobes", {mem_cs, mem_we, mem_oe, busy}, 0);
        @(negedge clk);
        reset = 1'b0;
        exp_rdata = 16'h0000;
        check("rst_rdata", int'(rdata), 0);
        count_acks(8, acks);
        check("rst_no_ack", acks, 0);
        run_access(tbl[6], 0);
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            case ($urandom_range(0, 3))
                0:       b = 8'h00;
                1:       b = 8'h80;
                default: b = 8'($urandom);
            endcase
            rv = model(b, 18'($urandom), 1'($urandom), 2'($urandom), 16'($urandom),
                       1'($urandom), 16'($urandom));
            run_access(rv, 0);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
